// File: rtl/spi_reg_ctrl.sv
// SPI mode-0 slave front-end for the game register bank.
// Synchronises sck/ss/mosi into clk, decodes a command byte (R/W, AI, address)
// and issues registered single-cycle read/write strobes to the bank.
module spi_reg_ctrl #(
  parameter int ADDR_W      = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sck,
  input  logic              ss,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_en,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [7:0]        reg_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  state_t                 state, state_next;
  logic [SYNC_STAGES-1:0] sck_s, ss_s, mosi_s;
  logic [SYNC_STAGES-1:0] fill;
  logic                   armed;
  logic                   sck_rise, sck_fall, ss_rise, ss_fall;
  logic                   ss_sync, mosi_sync;
  logic [2:0]             bit_cnt;
  logic [6:0]             rx_sr;
  logic [7:0]             rx_byte;
  logic                   byte_done;
  logic                   rd, ai;
  logic                   cap;
  logic [7:0]             hold;
  logic [6:0]             tx;
  logic                   frame_start, bit_en, cmd_done, data_done, tx_fall;

  // Input synchronisers, loaded with idle pin levels on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_s  <= '0;
      ss_s   <= '1;
      mosi_s <= '0;
    end else begin
      sck_s  <= {sck_s[SYNC_STAGES-2:0], sck};
      ss_s   <= {ss_s[SYNC_STAGES-2:0], ss};
      mosi_s <= {mosi_s[SYNC_STAGES-2:0], mosi};
    end
  end

  // Frame-start qualifier: the reset load of ss=1 would fake a falling edge if
  // the pin is already low at release, so a real high sample must be seen first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill  <= '0;
      armed <= 1'b0;
    end else begin
      fill  <= {fill[SYNC_STAGES-2:0], 1'b1};
      armed <= armed | (fill[SYNC_STAGES-1] & ss_sync);
    end
  end

  assign sck_rise  =  sck_s[SYNC_STAGES-2] & ~sck_s[SYNC_STAGES-1];
  assign sck_fall  = ~sck_s[SYNC_STAGES-2] &  sck_s[SYNC_STAGES-1];
  assign ss_rise   =  ss_s[SYNC_STAGES-2]  & ~ss_s[SYNC_STAGES-1];
  assign ss_fall   = ~ss_s[SYNC_STAGES-2]  &  ss_s[SYNC_STAGES-1];
  assign ss_sync   = ss_s[SYNC_STAGES-1];
  assign mosi_sync = mosi_s[SYNC_STAGES-1];
  assign rx_byte   = {rx_sr, mosi_sync};
  assign byte_done = sck_rise & (bit_cnt == 3'd7);
  assign miso_en   = ~ss_sync;
  assign busy      = ~ss_sync;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next state and per-cycle event decode; ss rising edge overrides everything.
  always_comb begin
    state_next  = state;
    frame_start = 1'b0;
    bit_en      = 1'b0;
    cmd_done    = 1'b0;
    data_done   = 1'b0;
    tx_fall     = 1'b0;
    if (ss_rise) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (ss_fall && armed) begin
            state_next  = CMD;
            frame_start = 1'b1;
          end
        end
        CMD: begin
          bit_en = sck_rise;
          if (byte_done) begin
            state_next = DATA;
            cmd_done   = 1'b1;
          end
        end
        DATA: begin
          bit_en    = sck_rise;
          data_done = byte_done;
          tx_fall   = sck_fall;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Datapath: bit counter, shift registers, address sequencing and strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= '0;
      rx_sr     <= '0;
      rd        <= 1'b0;
      ai        <= 1'b0;
      cap       <= 1'b0;
      hold      <= '0;
      tx        <= '0;
      miso      <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
    end else begin
      reg_we <= 1'b0;
      reg_re <= 1'b0;
      cap    <= reg_re;
      if (cap) hold <= reg_rdata;

      if (reg_we && ai) reg_addr <= reg_addr + ADDR_W'(1);

      if (frame_start) begin
        bit_cnt <= '0;
        miso    <= 1'b0;
      end
      if (ss_rise) miso <= 1'b0;

      if (bit_en) begin
        bit_cnt <= bit_cnt + 3'd1;
        rx_sr   <= rx_byte[6:0];
      end

      if (cmd_done) begin
        reg_addr <= rx_byte[ADDR_W-1:0];
        rd       <= rx_byte[7];
        ai       <= rx_byte[6];
        reg_re   <= rx_byte[7];
      end

      // Read prefetch: the address bump and the strobe land together, so the
      // strobe is seen with the already-incremented address.
      if (data_done) begin
        if (rd) begin
          if (ai) reg_addr <= reg_addr + ADDR_W'(1);
          reg_re <= 1'b1;
        end else begin
          reg_wdata <= rx_byte;
          reg_we    <= 1'b1;
        end
      end

      if (tx_fall) begin
        if (!rd) begin
          miso <= 1'b0;
        end else if (bit_cnt == 3'd0) begin
          tx   <= hold[6:0];
          miso <= hold[7];
        end else begin
          tx   <= {tx[5:0], 1'b0};
          miso <= tx[6];
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Self-checking bench for spi_reg_ctrl: directed frames plus randomised frames
// compared against a transaction-level model of the SPI register protocol.
module tb_spi_reg_ctrl;

  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;
  localparam int HALF   = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              sck = 1'b0;
  logic              ss = 1'b1;
  logic              mosi = 1'b0;
  logic              miso, miso_en, reg_we, reg_re, busy;
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_wdata;
  logic [7:0]        reg_rdata = 8'h00;

  always #5 clk = ~clk;

  spi_reg_ctrl #(.ADDR_W(ADDR_W), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .sck(sck), .ss(ss), .mosi(mosi),
    .miso(miso), .miso_en(miso_en), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
    .reg_rdata(reg_rdata), .busy(busy)
  );

  // Register bank model: data valid one clk after reg_re, junk otherwise.
  logic [7:0] mem [DEPTH];
  always @(posedge clk) reg_rdata <= reg_re ? mem[reg_addr] : 8'($urandom);

  // Strobe monitor.
  int we_addr_q[$], we_data_q[$], re_addr_q[$];
  int overlap = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (reg_we) begin
        we_addr_q.push_back(int'(reg_addr));
        we_data_q.push_back(int'(reg_wdata));
      end
      if (reg_re) re_addr_q.push_back(int'(reg_addr));
      if (reg_we && reg_re) overlap++;
    end
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Master side of mode 0: drive mosi while sck low, sample miso before rising.
  task automatic spi_bits(input logic [7:0] b, input int nb, output logic [7:0] r);
    r = '0;
    for (int i = 0; i < nb; i++) begin
      mosi = b[7-i];
      tick(HALF);
      r = {r[6:0], miso};
      sck = 1'b1;
      tick(HALF);
      sck = 1'b0;
    end
  endtask

  task automatic clear_mon();
    we_addr_q.delete();
    we_data_q.delete();
    re_addr_q.delete();
    overlap = 0;
  endtask

  logic [7:0] tx_data [8];

  // One frame: command, nb full data bytes, then part stray bits; expectations
  // come from the protocol rules (address sequence a + i*AI mod DEPTH).
  task automatic run_frame(input logic [7:0] cmd, input int nb, input int part, input string name);
    logic [7:0] rx;
    logic [7:0] rxd [8];
    int a, inc;
    clear_mon();
    ss = 1'b0;
    tick(HALF);
    check($sformatf("%s_busy_en", name), 32'({busy, miso_en}), 32'h3);
    spi_bits(cmd, 8, rx);
    check($sformatf("%s_cmd_miso", name), 32'(rx), 32'h0);
    for (int i = 0; i < nb; i++) spi_bits(tx_data[i], 8, rxd[i]);
    if (part > 0) spi_bits(8'($urandom), part, rx);
    tick(HALF);
    ss = 1'b1;
    tick(2 * HALF);
    check($sformatf("%s_idle_out", name), 32'({busy, miso_en, miso}), 32'h0);
    a   = int'(cmd[ADDR_W-1:0]);
    inc = cmd[6] ? 1 : 0;
    if (cmd[7]) begin
      check($sformatf("%s_we_cnt", name), 32'(we_addr_q.size()), 32'h0);
      check($sformatf("%s_re_cnt", name), 32'(re_addr_q.size()), 32'(nb + 1));
      for (int i = 0; i <= nb; i++)
        if (i < re_addr_q.size())
          check($sformatf("%s_re_addr%0d", name, i), 32'(re_addr_q[i]), 32'((a + i * inc) % DEPTH));
      for (int i = 0; i < nb; i++)
        check($sformatf("%s_rdata%0d", name, i), 32'(rxd[i]), 32'(mem[(a + i * inc) % DEPTH]));
    end else begin
      check($sformatf("%s_re_cnt", name), 32'(re_addr_q.size()), 32'h0);
      check($sformatf("%s_we_cnt", name), 32'(we_addr_q.size()), 32'(nb));
      for (int i = 0; i < nb; i++) begin
        if (i < we_addr_q.size()) begin
          check($sformatf("%s_we_addr%0d", name, i), 32'(we_addr_q[i]), 32'((a + i * inc) % DEPTH));
          check($sformatf("%s_we_data%0d", name, i), 32'(we_data_q[i]), 32'(tx_data[i]));
        end
        check($sformatf("%s_wr_miso%0d", name, i), 32'(rxd[i]), 32'h0);
      end
    end
    check($sformatf("%s_we_re_excl", name), 32'(overlap), 32'h0);
  endtask

  task automatic fill_mem();
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] rx;
    logic [7:0] cmd;
    int nb, part;
    fill_mem();

    // Reset state
    tick(3);
    check("rst_ctrl", 32'({miso, miso_en, reg_we, reg_re, busy}), 32'h0);
    check("rst_addr", 32'(reg_addr), 32'h0);
    check("rst_wdata", 32'(reg_wdata), 32'h0);
    rst_n = 1'b1;
    tick(10);

    // Single write
    tx_data[0] = 8'h3C;
    run_frame(8'h05, 1, 0, "wr1");

    // Burst write with address wrap
    tx_data[0] = 8'h11; tx_data[1] = 8'h22; tx_data[2] = 8'h33;
    run_frame(8'h7E, 3, 0, "wrwrap");

    // Single read
    mem[8'h12] = 8'hA5;
    tx_data[0] = 8'h00;
    run_frame(8'h92, 1, 0, "rd1");

    // Burst read with prefetch
    mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03;
    for (int i = 0; i < 3; i++) tx_data[i] = 8'($urandom);
    run_frame(8'hC0, 3, 0, "rdburst");

    // Abort after 5 data bits, then a normal frame
    run_frame(8'h08, 0, 5, "abort");
    tx_data[0] = 8'hFF;
    run_frame(8'h08, 1, 0, "postabort");

    // Reset mid-frame during the second data byte of a burst write
    clear_mon();
    ss = 1'b0;
    tick(HALF);
    spi_bits(8'h40, 8, rx);
    spi_bits(8'h11, 8, rx);
    spi_bits(8'h22, 4, rx);
    rst_n = 1'b0;
    #1;
    check("midrst_ctrl", 32'({miso, miso_en, reg_we, reg_re, busy}), 32'h0);
    check("midrst_addr", 32'(reg_addr), 32'h0);
    check("midrst_wdata", 32'(reg_wdata), 32'h0);
    sck = 1'b0;
    tick(3);
    clear_mon();
    rst_n = 1'b1;
    tick(4);
    spi_bits(8'h05, 8, rx);
    spi_bits(8'h3C, 8, rx);
    tick(HALF);
    check("midrst_no_we", 32'(we_addr_q.size()), 32'h0);
    check("midrst_no_re", 32'(re_addr_q.size()), 32'h0);
    ss = 1'b1;
    tick(2 * HALF);
    tx_data[0] = 8'h3C;
    run_frame(8'h05, 1, 0, "postrst");

    // Randomised frames
    for (int f = 0; f < 30; f++) begin
      fill_mem();
      cmd  = 8'($urandom);
      nb   = $urandom_range(1, 4);
      part = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      for (int i = 0; i < 8; i++) tx_data[i] = 8'($urandom);
      run_frame(cmd, nb, part, $sformatf("rnd%0d", f));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_reg_ctrl.md
Name: spi_reg_ctrl

Overview:
- SPI slave front-end that sequences host access to the game configuration/state register bank (brick map, paddle speed, colours, score).
- Samples sck/ss/mosi from ui_in pins in the clk domain, decodes a command byte, and issues single-cycle read/write strobes to the register bank.
- Drives miso/miso_en onto uio_out[0]/uio_oe[0]; the register bank is the only shared resource it controls.

Parameters:
- ADDR_W, 6, register address width; the address space is 2^ADDR_W bytes.
- SYNC_STAGES, 2, synchroniser flops per SPI input (allowed values 2 or 3).

Ports:
- clk  input  1  system clock (pixel clock domain)
- rst_n  input  1  asynchronous active-low reset
- sck  input  1  SPI clock, raw pin, CPOL=0
- ss  input  1  SPI select, raw pin, active-low
- mosi  input  1  SPI data in, raw pin
- miso  output  1  SPI data out
- miso_en  output  1  output enable for miso
- reg_addr  output  ADDR_W  register bank address
- reg_wdata  output  8  register bank write data
- reg_we  output  1  one-cycle write strobe
- reg_re  output  1  one-cycle read strobe
- reg_rdata  input  8  read data, valid exactly 1 clk after reg_re
- busy  output  1  high while a frame is active (ss low, synchronised)

Behaviour:
- Reset (rst_n low, asynchronous):
  - Synchronisers are loaded with idle values (sck=0, ss=1, mosi=0).
  - State goes to IDLE.
  - miso, miso_en, reg_we, reg_re and busy are 0; reg_addr and reg_wdata are 0.
  - The bit counter is 0.
- SPI mode 0 only:
  - mosi is sampled on the synchronised sck rising edge.
  - miso changes only on the synchronised sck falling edge, or on frame start.
  - MSB first.
  - The clk frequency must be at least 8x the sck frequency.
- Edge detection uses the last two synchroniser outputs. The ss falling edge starts a frame; the ss rising edge ends it.
- miso_en and busy equal the synchronised ss, inverted.
- State IDLE:
  - On the ss falling edge go to CMD, clear the bit counter and drive miso to 0.
- State CMD: receive 8 bits of the command byte.
  - bit7 = R/W (1 = read).
  - bit6 = AI (auto-increment).
  - bits[ADDR_W-1:0] = start address; for ADDR_W < 6, bits [5:ADDR_W] are ignored.
  - miso stays 0 throughout the command byte.
  - On the 8th rising edge: latch the address into reg_addr and go to DATA.
  - If R/W = 1, also assert reg_re in the cycle after the edge is detected, and capture reg_rdata into a tx holding register on the next cycle.
- State DATA, write frame:
  - Each 8th rising edge of a data byte assigns reg_wdata = the received byte and pulses reg_we for exactly 1 clk.
  - reg_addr is stable during the pulse.
  - In the cycle after reg_we, if AI = 1, reg_addr increments modulo 2^ADDR_W. Address 2^ADDR_W-1 wraps to 0.
  - If AI = 0, reg_addr is held and repeated bytes rewrite the same register.
  - miso outputs 0 during write frames.
- State DATA, read frame:
  - On every sck falling edge where the bit counter is 0 (the byte boundary), the tx shift register loads the holding register and miso = bit7.
  - On the other falling edges, the shift register shifts left and miso = the new bit7.
  - On each 8th rising edge of a data byte: first increment reg_addr if AI = 1 (same wrap rule), then pulse reg_re, then capture into the holding register, to prefetch the next byte.
  - mosi bits received during a read frame are ignored.
- Bit counter:
  - 3 bits, incremented on each rising edge, wrapping 7 to 0.
  - Byte completion is the rising edge on which the counter is 7.
- ss rising edge, any state:
  - Return to IDLE and drive miso to 0.
  - A partial byte (fewer than 8 bits) is discarded with no reg_we.
  - A reg_re or capture already in flight completes, but its data is never shifted out.
- Simultaneous events:
  - An ss rising edge detected in the same clk as an sck rising edge: the ss edge wins and no strobe is issued.
  - reg_we and reg_re are never both high.
- Glitch-free: reg_we and reg_re are registered outputs.
- Reset asserted mid-frame:
  - Immediate return to reset values.
  - After release the block waits for a fresh ss falling edge. An ss already low at release does not start a frame.

Test Plan:
- Single write:
  - ss low, shift 0x05 then 0x3C, ss high.
  - Expect exactly one reg_we pulse with reg_addr=0x05 and reg_wdata=0x3C; miso=0 throughout.
- Burst write with wrap:
  - Command 0x7E (write, AI, addr 0x3E), then data 0x11, 0x22, 0x33.
  - Expect reg_we at addresses 0x3E, 0x3F, 0x00 with the matching data.
- Single read:
  - Bank model returns 0xA5 at address 0x12. Send command 0x92, then clock 8 more bits.
  - Expect reg_re with reg_addr=0x12 and miso bits 1,0,1,0,0,1,0,1; miso_en=1 only while ss is low.
- Burst read:
  - Command 0xC0 (read, AI, addr 0), bank contents 0x01, 0x02, 0x03; clock 3 data bytes.
  - Expect miso to return 0x01, 0x02, 0x03 and reg_re at addresses 0, 1, 2, plus a prefetch at 3.
- Abort:
  - Command 0x08, then 5 data bits, then ss high.
  - Expect no reg_we, state IDLE, miso=0.
  - A following full frame 0x08 then 0xFF writes 0xFF to address 0x08 normally.
- Reset mid-frame:
  - rst_n low during the second data byte of a burst write.
  - Expect all outputs 0 immediately. With ss still low after release, no strobe occurs until ss toggles high then low again.
